// File: rtl/pc060ha_pkg.sv
// Shared types and helpers for the PC060HA master-side sequencer.
package pc060ha_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_READ   = 2'b01,
      OP_STATUS = 2'b10,
      OP_CTRL   = 2'b11
   } op_t;

   localparam logic [3:0] IDX_MBOX0 = 4'd0;
   localparam logic [3:0] IDX_MBOX1 = 4'd2;
   localparam logic [3:0] IDX_CTRL  = 4'd4;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      GAP
   } phase_t;

   typedef enum logic {
      CMD_IDLE,
      CMD_BUSY
   } cmd_state_t;

   typedef struct packed {
      logic       is_write;
      logic       a0;
      logic [3:0] wdata;
   } access_t;

   // Index of the final access of a command (accesses are numbered from 0).
   function automatic logic [1:0] last_step(op_t op);
      return (op == OP_WRITE || op == OP_READ) ? 2'd2 : 2'd1;
   endfunction

   // Access 0 writes the index; later accesses hit the auto-incrementing data port.
   function automatic access_t access_of(op_t op, logic rsel, logic [7:0] data,
                                         logic [1:0] step);
      access_t acc;
      acc = '0;
      if (step == 2'd0) begin
         acc.is_write = 1'b1;
         acc.a0       = 1'b0;
         if (op == OP_WRITE || op == OP_READ)
            acc.wdata = rsel ? IDX_MBOX1 : IDX_MBOX0;
         else
            acc.wdata = IDX_CTRL;
      end else begin
         acc.a0       = 1'b1;
         acc.is_write = (op == OP_WRITE || op == OP_CTRL);
         if (acc.is_write)
            acc.wdata = (step == 2'd2) ? data[7:4] : data[3:0];
      end
      return acc;
   endfunction

endpackage

// File: rtl/pc060ha_master_if_if.sv
// Command mailbox handshake plus PC060HA master-port pins.
interface pc060ha_master_if_if;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic       CMD_REG;
   logic [7:0] CMD_DATA;
   logic       RSP_VALID;
   logic [7:0] RSP_DATA;
   logic       nMCS;
   logic       nMRD;
   logic       nMWR;
   logic       MA0;
   logic [3:0] MD_OUT;
   logic       MD_OE;
   logic [3:0] MD_IN;

   modport master (
      input  CMD_VALID, CMD_OP, CMD_REG, CMD_DATA, MD_IN,
      output CMD_READY, RSP_VALID, RSP_DATA, nMCS, nMRD, nMWR, MA0, MD_OUT, MD_OE
   );

   modport slave (
      output CMD_VALID, CMD_OP, CMD_REG, CMD_DATA, MD_IN,
      input  CMD_READY, RSP_VALID, RSP_DATA, nMCS, nMRD, nMWR, MA0, MD_OUT, MD_OE
   );
endinterface

// File: rtl/pc060ha_bus_cycle.sv
// Single-access timing engine: SETUP -> STROBE -> HOLD -> GAP with every pin from a flop.
module pc060ha_bus_cycle
   import pc060ha_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned GAP_CYC    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       is_write,
   input  logic       a0,
   input  logic [3:0] wdata,
   input  logic [3:0] md_in,
   output logic       ncs,
   output logic       nrd,
   output logic       nwr,
   output logic       ma0,
   output logic [3:0] md_out,
   output logic       md_oe,
   output logic       done_c,
   output logic [3:0] rdata
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   phase_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic             ncs_d, nrd_d, nwr_d, ma0_d, oe_d;
   logic [3:0]       md_d, rdata_d;
   logic             load;

   // Phase sequencing and next values of the registered pins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      ma0_d   = ma0;
      md_d    = md_out;
      oe_d    = md_oe;
      rdata_d = rdata;
      done_c  = 1'b0;
      load    = 1'b0;

      case (state_q)
         IDLE: load = start;
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
               if (!wr_q) rdata_d = md_in;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               if (GAP_CYC == 0) begin
                  done_c  = 1'b1;
                  load    = start;
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_LD;
                  oe_d    = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               done_c  = 1'b1;
               load    = start;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // MA0 only changes here, entering SETUP with nMCS high.
      if (load) begin
         state_d = SETUP;
         cnt_d   = SETUP_LD;
         wr_d    = is_write;
         ma0_d   = a0;
         md_d    = wdata;
         oe_d    = is_write;
      end else if (state_d == IDLE) begin
         oe_d = 1'b0;
      end

      ncs_d = (state_d != STROBE);
      nwr_d = !(state_d == STROBE && wr_d);
      nrd_d = !(state_d == STROBE && !wr_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         ncs     <= 1'b1;
         nrd     <= 1'b1;
         nwr     <= 1'b1;
         ma0     <= 1'b0;
         md_out  <= '0;
         md_oe   <= 1'b0;
         rdata   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         ncs     <= ncs_d;
         nrd     <= nrd_d;
         nwr     <= nwr_d;
         ma0     <= ma0_d;
         md_out  <= md_d;
         md_oe   <= oe_d;
         rdata   <= rdata_d;
      end
   end

endmodule

// File: rtl/pc060ha_master_if.sv
// Byte-level mailbox command sequencer for the PC060HA nibble-wide master port.
module pc060ha_master_if
   import pc060ha_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned GAP_CYC    = 1
) (
   input logic                 MCLK,
   input logic                 RESET,
   pc060ha_master_if_if.master bus
);

   cmd_state_t state_q, state_d;
   op_t        op_q, op_d;
   logic       reg_q, reg_d;
   logic [7:0] data_q, data_d;
   logic [1:0] step_q, step_d;
   logic [3:0] lo_q, lo_d;
   logic       ready_q, ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   logic       start_c;
   logic       done_c;
   access_t    acc_c;
   logic [3:0] rdata;

   logic       bc_ncs, bc_nrd, bc_nwr, bc_ma0, bc_oe;
   logic [3:0] bc_md;

   // Command acceptance, step advance and response assembly.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      reg_d       = reg_q;
      data_d      = data_q;
      step_d      = step_q;
      lo_d        = lo_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      start_c     = 1'b0;
      acc_c       = access_of(op_q, reg_q, data_q, step_q + 2'd1);

      case (state_q)
         CMD_IDLE: begin
            if (ready_q && bus.CMD_VALID) begin
               state_d = CMD_BUSY;
               op_d    = op_t'(bus.CMD_OP);
               reg_d   = bus.CMD_REG;
               data_d  = bus.CMD_DATA;
               step_d  = 2'd0;
               start_c = 1'b1;
               acc_c   = access_of(op_t'(bus.CMD_OP), bus.CMD_REG, bus.CMD_DATA, 2'd0);
            end
         end
         CMD_BUSY: begin
            if (done_c) begin
               if (step_q == last_step(op_q)) begin
                  state_d = CMD_IDLE;
                  if (op_q == OP_READ) begin
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = {rdata, lo_q};
                  end else if (op_q == OP_STATUS) begin
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = {4'h0, rdata};
                  end
               end else begin
                  step_d  = step_q + 2'd1;
                  start_c = 1'b1;
                  if (op_q == OP_READ && step_q == 2'd1) lo_d = rdata;
               end
            end
         end
         default: state_d = CMD_IDLE;
      endcase

      ready_d = (state_d == CMD_IDLE);
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         state_q     <= CMD_IDLE;
         op_q        <= OP_WRITE;
         reg_q       <= 1'b0;
         data_q      <= '0;
         step_q      <= '0;
         lo_q        <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         step_q      <= step_d;
         lo_q        <= lo_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   pc060ha_bus_cycle #(
      .SETUP_CYC (SETUP_CYC),
      .STROBE_CYC(STROBE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .GAP_CYC   (GAP_CYC)
   ) u_bus_cycle (
      .clk     (MCLK),
      .rst     (RESET),
      .start   (start_c),
      .is_write(acc_c.is_write),
      .a0      (acc_c.a0),
      .wdata   (acc_c.wdata),
      .md_in   (bus.MD_IN),
      .ncs     (bc_ncs),
      .nrd     (bc_nrd),
      .nwr     (bc_nwr),
      .ma0     (bc_ma0),
      .md_out  (bc_md),
      .md_oe   (bc_oe),
      .done_c  (done_c),
      .rdata   (rdata)
   );

   assign bus.CMD_READY = ready_q;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_DATA  = rsp_data_q;
   assign bus.nMCS      = bc_ncs;
   assign bus.nMRD      = bc_nrd;
   assign bus.nMWR      = bc_nwr;
   assign bus.MA0       = bc_ma0;
   assign bus.MD_OUT    = bc_md;
   assign bus.MD_OE     = bc_oe;

endmodule

// File: tb/tb_pc060ha_master_if.sv
// Directed bench for pc060ha_master_if: default timing instance plus a GAP_CYC=0 instance.
module tb_pc060ha_master_if;
   import pc060ha_pkg::*;

   logic MCLK = 1'b0;
   logic RESET;
   always #5 MCLK = ~MCLK;

   pc060ha_master_if_if bus_a ();
   pc060ha_master_if_if bus_b ();

   pc060ha_master_if dut_a (.MCLK(MCLK), .RESET(RESET), .bus(bus_a));
   pc060ha_master_if #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .GAP_CYC(0))
      dut_b (.MCLK(MCLK), .RESET(RESET), .bus(bus_b));

   assign bus_b.MD_IN = 4'h0;

   int total = 0;
   int bad   = 0;

   // Chip model for instance A: logs each access and serves read nibbles in order.
   logic [3:0] rd_vals [4] = '{4'h3, 4'hC, 4'h9, 4'h0};
   int   rd_ptr = 0;
   logic m_ma0 [$];
   logic m_wr  [$];
   logic [3:0] m_md [$];
   logic prev_ncs = 1'b1, prev_ma0 = 1'b0, have_prev = 1'b0;
   int   hi_run = 0, min_hi = 1000, ma0_err = 0, oe_err = 0, wr_low = 0;

   always @(negedge MCLK) begin
      if (!bus_a.nMCS && prev_ncs) begin
         m_ma0.push_back(bus_a.MA0);
         m_wr.push_back(!bus_a.nMWR);
         m_md.push_back(bus_a.MD_OUT);
         if (have_prev && hi_run < min_hi) min_hi = hi_run;
         have_prev = 1'b1;
         hi_run    = 0;
         if (!bus_a.nMRD && rd_ptr < 4) begin
            bus_a.MD_IN = rd_vals[rd_ptr[1:0]];
            rd_ptr++;
         end
      end
      if (bus_a.nMCS) hi_run++;
      if (!bus_a.nMCS && bus_a.MA0 !== prev_ma0) ma0_err++;
      if (!bus_a.nMRD && bus_a.MD_OE) oe_err++;
      if (!bus_a.nMWR) wr_low++;
      prev_ncs = bus_a.nMCS;
      prev_ma0 = bus_a.MA0;
   end

   logic mb_ma0 [$];
   logic [3:0] mb_md [$];
   logic prev_ncs_b = 1'b1, prev_ma0_b = 1'b0;
   int   ma0_err_b = 0, wr_low_b = 0;

   always @(negedge MCLK) begin
      if (!bus_b.nMCS && prev_ncs_b) begin
         mb_ma0.push_back(bus_b.MA0);
         mb_md.push_back(bus_b.MD_OUT);
      end
      if (!bus_b.nMCS && bus_b.MA0 !== prev_ma0_b) ma0_err_b++;
      if (!bus_b.nMWR) wr_low_b++;
      prev_ncs_b = bus_b.nMCS;
      prev_ma0_b = bus_b.MA0;
   end

   // Issue one command on A; lat = cycles from acceptance edge to the first IDLE cycle.
   task automatic issue(input logic [1:0] op, input logic rs, input logic [7:0] d,
                        output int lat, output int nrsp, output logic [7:0] rsp);
      lat  = -1;
      nrsp = 0;
      rsp  = 8'h00;
      @(negedge MCLK);
      bus_a.CMD_OP    = op;
      bus_a.CMD_REG   = rs;
      bus_a.CMD_DATA  = d;
      bus_a.CMD_VALID = 1'b1;
      for (int i = 0; i < 50 && !bus_a.CMD_READY; i++) @(negedge MCLK);
      @(posedge MCLK);
      #1 bus_a.CMD_VALID = 1'b0;
      for (int j = 1; j <= 60; j++) begin
         @(negedge MCLK);
         if (bus_a.RSP_VALID) begin
            nrsp++;
            rsp = bus_a.RSP_DATA;
         end
         if (bus_a.CMD_READY) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int rsp_seen, ncs_low;
      RESET = 1'b1;
      repeat (3) @(posedge MCLK);
      @(negedge MCLK);
      total++;
      if ({bus_a.nMCS, bus_a.nMRD, bus_a.nMWR, bus_a.MA0, bus_a.MD_OUT, bus_a.MD_OE} !== 9'b111_0_0000_0) begin
         bad++;
         $display("FAIL reset_pins: got %b want 111000000",
                  {bus_a.nMCS, bus_a.nMRD, bus_a.nMWR, bus_a.MA0, bus_a.MD_OUT, bus_a.MD_OE});
      end
      total++;
      if ({bus_a.RSP_VALID, bus_a.RSP_DATA, bus_a.CMD_READY, bus_b.CMD_READY} !== 11'b0) begin
         bad++;
         $display("FAIL reset_rsp_ready: got %b want 0",
                  {bus_a.RSP_VALID, bus_a.RSP_DATA, bus_a.CMD_READY, bus_b.CMD_READY});
      end
      RESET = 1'b0;
      @(negedge MCLK);
      total++;
      if (bus_a.CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset: got %b want 1", bus_a.CMD_READY);
      end
      // Abort a WRITE in its first STROBE cycle.
      bus_a.CMD_OP    = OP_WRITE;
      bus_a.CMD_REG   = 1'b1;
      bus_a.CMD_DATA  = 8'hA5;
      bus_a.CMD_VALID = 1'b1;
      @(posedge MCLK);
      #1 bus_a.CMD_VALID = 1'b0;
      @(negedge MCLK);
      @(negedge MCLK);
      total++;
      if ({bus_a.nMCS, bus_a.nMWR} !== 2'b00) begin
         bad++;
         $display("FAIL first_strobe: got %b want 00", {bus_a.nMCS, bus_a.nMWR});
      end
      RESET = 1'b1;
      @(negedge MCLK);
      total++;
      if ({bus_a.nMCS, bus_a.nMRD, bus_a.nMWR, bus_a.MA0, bus_a.MD_OUT, bus_a.MD_OE, bus_a.CMD_READY}
          !== 10'b111_0_0000_0_0) begin
         bad++;
         $display("FAIL midwrite_reset: got %b want 1110000000",
                  {bus_a.nMCS, bus_a.nMRD, bus_a.nMWR, bus_a.MA0, bus_a.MD_OUT, bus_a.MD_OE, bus_a.CMD_READY});
      end
      RESET = 1'b0;
      @(negedge MCLK);
      total++;
      if (bus_a.CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_abort: got %b want 1", bus_a.CMD_READY);
      end
      rsp_seen = 0;
      ncs_low  = 0;
      repeat (20) begin
         @(negedge MCLK);
         if (bus_a.RSP_VALID) rsp_seen++;
         if (!bus_a.nMCS) ncs_low++;
      end
      total++;
      if (rsp_seen != 0 || ncs_low != 0) begin
         bad++;
         $display("FAIL abort_quiet: rsp=%0d ncs_low=%0d want 0 0", rsp_seen, ncs_low);
      end
   endtask

   task automatic test_write();
      int lat, nrsp, base, w0;
      logic [7:0] rsp;
      logic [5:0] exp_acc [3];
      exp_acc[0] = 6'b0_1_0010;
      exp_acc[1] = 6'b1_1_0101;
      exp_acc[2] = 6'b1_1_1010;
      base = m_ma0.size();
      w0   = wr_low;
      issue(OP_WRITE, 1'b1, 8'hA5, lat, nrsp, rsp);
      total++;
      if (lat != 16 || nrsp != 0) begin
         bad++;
         $display("FAIL write_latency: lat=%0d rsp=%0d want 16 0", lat, nrsp);
      end
      total++;
      if (m_ma0.size() - base != 3) begin
         bad++;
         $display("FAIL write_count: got %0d want 3", m_ma0.size() - base);
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if ({m_ma0[base+k], m_wr[base+k], m_md[base+k]} !== exp_acc[k]) begin
               bad++;
               $display("FAIL write_acc%0d: got %b want %b", k,
                        {m_ma0[base+k], m_wr[base+k], m_md[base+k]}, exp_acc[k]);
            end
         end
      end
      total++;
      if (wr_low - w0 != 6) begin
         bad++;
         $display("FAIL write_strobe_len: got %0d want 6", wr_low - w0);
      end
   endtask

   task automatic test_read();
      int lat, nrsp, base, o0;
      logic [7:0] rsp;
      base = m_ma0.size();
      o0   = oe_err;
      issue(OP_READ, 1'b0, 8'h00, lat, nrsp, rsp);
      total++;
      if (lat != 16 || nrsp != 1 || rsp !== 8'hC3) begin
         bad++;
         $display("FAIL read_rsp: lat=%0d n=%0d data=%h want 16 1 c3", lat, nrsp, rsp);
      end
      total++;
      if (m_ma0.size() - base != 3) begin
         bad++;
         $display("FAIL read_count: got %0d want 3", m_ma0.size() - base);
      end else begin
         total++;
         if ({m_ma0[base], m_wr[base], m_md[base], m_ma0[base+1], m_wr[base+1],
              m_ma0[base+2], m_wr[base+2]} !== 10'b0_1_0000_10_10) begin
            bad++;
            $display("FAIL read_seq: got %b want 0100001010",
                     {m_ma0[base], m_wr[base], m_md[base], m_ma0[base+1], m_wr[base+1],
                      m_ma0[base+2], m_wr[base+2]});
         end
      end
      total++;
      if (oe_err != o0) begin
         bad++;
         $display("FAIL read_oe: got %0d cycles with MD_OE during read want 0", oe_err - o0);
      end
      @(negedge MCLK);
      total++;
      if (bus_a.RSP_VALID !== 1'b0 || bus_a.RSP_DATA !== 8'hC3) begin
         bad++;
         $display("FAIL read_pulse: valid=%b data=%h want 0 c3", bus_a.RSP_VALID, bus_a.RSP_DATA);
      end
   endtask

   task automatic test_status_ctrl();
      int lat, nrsp, base;
      logic [7:0] rsp;
      base = m_ma0.size();
      issue(OP_STATUS, 1'b0, 8'h00, lat, nrsp, rsp);
      total++;
      if (lat != 11 || nrsp != 1 || rsp !== 8'h09) begin
         bad++;
         $display("FAIL status_rsp: lat=%0d n=%0d data=%h want 11 1 09", lat, nrsp, rsp);
      end
      total++;
      if (m_ma0.size() - base != 2 ||
          {m_ma0[base], m_wr[base], m_md[base], m_ma0[base+1], m_wr[base+1]} !== 8'b0_1_0100_10) begin
         bad++;
         $display("FAIL status_seq: n=%0d want 2 (idx-wr 4, rd)", m_ma0.size() - base);
      end
      base = m_ma0.size();
      issue(OP_CTRL, 1'b0, 8'h01, lat, nrsp, rsp);
      total++;
      if (lat != 11 || nrsp != 0) begin
         bad++;
         $display("FAIL ctrl_latency: lat=%0d rsp=%0d want 11 0", lat, nrsp);
      end
      total++;
      if (m_ma0.size() - base != 2 ||
          {m_ma0[base], m_wr[base], m_md[base], m_ma0[base+1], m_wr[base+1], m_md[base+1]}
          !== 12'b0_1_0100_1_1_0001) begin
         bad++;
         $display("FAIL ctrl_seq: n=%0d want 2 (idx-wr 4, wr 1)", m_ma0.size() - base);
      end
      total++;
      if (bus_a.RSP_DATA !== 8'h09) begin
         bad++;
         $display("FAIL rsp_hold: got %h want 09", bus_a.RSP_DATA);
      end
   endtask

   task automatic test_back_to_back();
      int times [3] = '{0, 0, 0};
      int acc_n = 0, done_n = -1, base;
      logic prev_rdy = 1'b0;
      base = m_ma0.size();
      @(negedge MCLK);
      bus_a.CMD_OP    = OP_WRITE;
      bus_a.CMD_REG   = 1'b0;
      bus_a.CMD_DATA  = 8'h5A;
      bus_a.CMD_VALID = 1'b1;
      for (int n = 0; n < 80; n++) begin
         if (n > 0) @(negedge MCLK);
         if (prev_rdy) begin
            total++;
            if ({bus_a.nMCS, bus_a.MA0, bus_a.MD_OE, bus_a.MD_OUT, bus_a.CMD_READY} !== 8'b1_0_1_0000_0) begin
               bad++;
               $display("FAIL b2b_setup: got %b want 10100000",
                        {bus_a.nMCS, bus_a.MA0, bus_a.MD_OE, bus_a.MD_OUT, bus_a.CMD_READY});
            end
         end
         if (acc_n == 3 && bus_a.CMD_READY && n > times[2]) begin
            done_n = n;
            break;
         end
         prev_rdy = bus_a.CMD_READY && acc_n < 3;
         if (prev_rdy) begin
            times[acc_n] = n;
            acc_n++;
            if (acc_n == 3) begin
               @(posedge MCLK);
               #1 bus_a.CMD_VALID = 1'b0;
            end
         end
      end
      total++;
      if (acc_n != 3 || times[1] - times[0] != 16 || times[2] - times[1] != 16 || done_n - times[2] != 16) begin
         bad++;
         $display("FAIL b2b_accept: n=%0d t=%0d,%0d,%0d end=%0d want 3 0,16,32 48",
                  acc_n, times[0], times[1], times[2], done_n);
      end
      total++;
      if (m_ma0.size() - base != 9) begin
         bad++;
         $display("FAIL b2b_count: got %0d want 9", m_ma0.size() - base);
      end
      total++;
      if (min_hi < 2 || ma0_err != 0) begin
         bad++;
         $display("FAIL bus_rules: min_ncs_high=%0d ma0_changes=%0d want >=2 0", min_hi, ma0_err);
      end
   endtask

   task automatic test_sweep();
      int lat = -1, base, w0;
      base = mb_ma0.size();
      w0   = wr_low_b;
      @(negedge MCLK);
      total++;
      if (bus_b.CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL sweep_ready: got %b want 1", bus_b.CMD_READY);
      end
      bus_b.CMD_OP    = OP_WRITE;
      bus_b.CMD_REG   = 1'b0;
      bus_b.CMD_DATA  = 8'h3C;
      bus_b.CMD_VALID = 1'b1;
      @(posedge MCLK);
      #1 bus_b.CMD_VALID = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge MCLK);
         if (bus_b.CMD_READY) begin
            lat = j;
            break;
         end
      end
      total++;
      if (lat != 10) begin
         bad++;
         $display("FAIL sweep_latency: got %0d want 10", lat);
      end
      total++;
      if (mb_ma0.size() - base != 3 ||
          {mb_ma0[base], mb_md[base], mb_ma0[base+1], mb_md[base+1], mb_ma0[base+2], mb_md[base+2]}
          !== 15'b0_0000_1_1100_1_0011) begin
         bad++;
         $display("FAIL sweep_seq: n=%0d want 3 (0/0, 1/C, 1/3)", mb_ma0.size() - base);
      end
      total++;
      if (ma0_err_b != 0 || wr_low_b - w0 != 3) begin
         bad++;
         $display("FAIL sweep_rules: ma0_changes=%0d wr_low=%0d want 0 3", ma0_err_b, wr_low_b - w0);
      end
   endtask

   initial begin
      RESET           = 1'b1;
      bus_a.CMD_VALID = 1'b0;
      bus_a.CMD_OP    = 2'b00;
      bus_a.CMD_REG   = 1'b0;
      bus_a.CMD_DATA  = 8'h00;
      bus_b.CMD_VALID = 1'b0;
      bus_b.CMD_OP    = 2'b00;
      bus_b.CMD_REG   = 1'b0;
      bus_b.CMD_DATA  = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_status_ctrl();
      test_back_to_back();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
